beacon_scheduler: RTL and testbench

Beacon scheduler in the xpu: from the running TSF and a programmed beacon interval, it computes each target beacon transmission time (TBTT). It issues a one-cycle `start_beaconing` request early by the measured TX processing delay, then waits for `sent_beacon` before scheduling the next beacon. It sits between the register interface / TSF timer and the TX path, and counts missed TBTTs and TX timeouts for software.

---
 rtl/beacon_sched_pkg.sv | 17 +
 rtl/beacon_tbtt_gen.sv | 64 ++++++
 rtl/beacon_scheduler.sv | 160 ++++++++++++++++
 tb/tb_beacon_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beacon_sched_pkg.sv
// rtl/beacon_sched_pkg.sv - shared widths and FSM state encoding for the beacon scheduler
package beacon_sched_pkg;

    localparam int DEF_TIMER_WIDTH    = 64;
    localparam int DEF_INTERVAL_WIDTH = 32;
    localparam int DEF_LEAD_WIDTH     = 16;
    localparam int DEF_CNT_WIDTH      = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT      = 3'd2,
        ST_FIRE      = 3'd3,
        ST_WAIT_SENT = 3'd4
    } sched_state_e;

endpackage

// File: rtl/beacon_tbtt_gen.sv
// rtl/beacon_tbtt_gen.sv - TBTT register, seed/advance adders, lead clamp and registered compares
module beacon_tbtt_gen
    import beacon_sched_pkg::*;
#(
    parameter int TIMER_WIDTH    = DEF_TIMER_WIDTH,
    parameter int INTERVAL_WIDTH = DEF_INTERVAL_WIDTH,
    parameter int LEAD_WIDTH     = DEF_LEAD_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [TIMER_WIDTH-1:0]    tsf_runtime_val,
    input  logic [INTERVAL_WIDTH-1:0] beacon_interval,
    input  logic [LEAD_WIDTH-1:0]     max_lead,
    input  logic [TIMER_WIDTH-1:0]    prosessing_delay,
    input  logic                      seed,
    input  logic                      advance,
    output logic [TIMER_WIDTH-1:0]    next_tbtt,
    output logic                      fire_due,
    output logic                      missed
);

    logic [TIMER_WIDTH-1:0] next_tbtt_q, next_tbtt_d;
    logic [LEAD_WIDTH-1:0]  lead_q, lead_d;
    logic                   fire_due_q, fire_due_d;
    logic                   missed_q, missed_d;
    logic [TIMER_WIDTH-1:0] tsf_lead;

    always_comb begin
        if (prosessing_delay > TIMER_WIDTH'(max_lead)) begin
            lead_d = max_lead;
        end else begin
            lead_d = prosessing_delay[LEAD_WIDTH-1:0];
        end
        next_tbtt_d = next_tbtt_q;
        if (seed) begin
            next_tbtt_d = tsf_runtime_val + TIMER_WIDTH'(beacon_interval);
        end else if (advance) begin
            next_tbtt_d = next_tbtt_q + TIMER_WIDTH'(beacon_interval);
        end
        // Compare against the value being written so the flags are never one TBTT stale.
        tsf_lead   = tsf_runtime_val + TIMER_WIDTH'(lead_q);
        fire_due_d = (tsf_lead >= next_tbtt_d);
        missed_d   = (tsf_lead > next_tbtt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_tbtt_q <= '0;
            lead_q      <= '0;
            fire_due_q  <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            next_tbtt_q <= next_tbtt_d;
            lead_q      <= lead_d;
            fire_due_q  <= fire_due_d;
            missed_q    <= missed_d;
        end
    end

    assign next_tbtt = next_tbtt_q;
    assign fire_due  = fire_due_q;
    assign missed    = missed_q;

endmodule

// File: rtl/beacon_scheduler.sv
// rtl/beacon_scheduler.sv - beacon scheduling FSM with miss and TX-timeout counters
// Optional TX timeout is compiled in with BEACON_TIMEOUT_EN.
module beacon_scheduler
    import beacon_sched_pkg::*;
#(
    parameter int TIMER_WIDTH    = DEF_TIMER_WIDTH,
    parameter int INTERVAL_WIDTH = DEF_INTERVAL_WIDTH,
    parameter int LEAD_WIDTH     = DEF_LEAD_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [INTERVAL_WIDTH-1:0] beacon_interval,
    input  logic [LEAD_WIDTH-1:0]     max_lead,
    input  logic [INTERVAL_WIDTH-1:0] timeout_us,
    input  logic [TIMER_WIDTH-1:0]    tsf_runtime_val,
    input  logic                      tsf_load,
    input  logic [TIMER_WIDTH-1:0]    prosessing_delay,
    input  logic                      sent_beacon,
    output logic                      start_beaconing,
    output logic                      beacon_busy,
    output logic [TIMER_WIDTH-1:0]    next_tbtt,
    output logic [CNT_WIDTH-1:0]      miss_count,
    output logic [CNT_WIDTH-1:0]      timeout_count,
    output logic [2:0]                sched_state
);

    sched_state_e         state_q, state_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] miss_q, miss_d;
    logic [CNT_WIDTH-1:0] tmo_q, tmo_d;
    logic                 seed, advance, fire_due, missed, active, timeout_hit;

    beacon_tbtt_gen #(
        .TIMER_WIDTH    (TIMER_WIDTH),
        .INTERVAL_WIDTH (INTERVAL_WIDTH),
        .LEAD_WIDTH     (LEAD_WIDTH)
    ) u_tbtt_gen (
        .clk              (clk),
        .rst              (rst),
        .tsf_runtime_val  (tsf_runtime_val),
        .beacon_interval  (beacon_interval),
        .max_lead         (max_lead),
        .prosessing_delay (prosessing_delay),
        .seed             (seed),
        .advance          (advance),
        .next_tbtt        (next_tbtt),
        .fire_due         (fire_due),
        .missed           (missed)
    );

`ifdef BEACON_TIMEOUT_EN
    logic [TIMER_WIDTH-1:0] entry_q, entry_d;

    // A TSF reload re-bases the pending timeout onto the new time line.
    always_comb begin
        entry_d = entry_q;
        if (tsf_load || (state_q == ST_FIRE)) begin
            entry_d = tsf_runtime_val;
        end
        timeout_hit = busy_q && (state_q != ST_FIRE) && (timeout_us != '0) &&
                      ((tsf_runtime_val - entry_q) >= TIMER_WIDTH'(timeout_us));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_us;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        active  = enable && (beacon_interval != '0);
        state_d = state_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        miss_d  = miss_q;
        tmo_d   = tmo_q;
        seed    = 1'b0;
        advance = 1'b0;
        if (!active) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            if (busy_q && (state_q != ST_FIRE)) begin
                if (sent_beacon) begin
                    busy_d = 1'b0;
                end else if (timeout_hit) begin
                    busy_d = 1'b0;
                    tmo_d  = (&tmo_q) ? tmo_q : tmo_q + CNT_WIDTH'(1);
                end
            end
            if (tsf_load && (state_q != ST_IDLE)) begin
                seed    = 1'b1;
                state_d = ST_WAIT;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        seed    = 1'b1;
                        state_d = ST_WAIT;
                    end
                    ST_ARM: begin
                        if (missed) begin
                            advance = 1'b1;
                            miss_d  = (&miss_q) ? miss_q : miss_q + CNT_WIDTH'(1);
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (fire_due && !busy_q) begin
                            state_d = ST_FIRE;
                            start_d = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                    ST_FIRE: state_d = ST_WAIT_SENT;
                    ST_WAIT_SENT: begin
                        if (sent_beacon || timeout_hit) begin
                            advance = 1'b1;
                            state_d = ST_ARM;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            miss_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            miss_q  <= miss_d;
            tmo_q   <= tmo_d;
        end
    end

    assign start_beaconing = start_q;
    assign beacon_busy     = busy_q;
    assign miss_count      = miss_q;
    assign timeout_count   = tmo_q;
    assign sched_state     = state_q;

endmodule

// File: tb/tb_beacon_scheduler.sv
// tb/tb_beacon_scheduler.sv - self-checking bench for beacon_scheduler against a TBTT arithmetic model
module tb_beacon_scheduler;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [31:0]   beacon_interval = '0;
    logic [15:0]   max_lead = '0;
    logic [31:0]   timeout_us = '0;
    logic [63:0]   tsf_runtime_val = '0;
    logic          tsf_load = 1'b0;
    logic [63:0]   prosessing_delay = '0;
    logic          sent_beacon = 1'b0;
    logic          start_beaconing;
    logic          beacon_busy;
    logic [63:0]   next_tbtt;
    logic [CW-1:0] miss_count;
    logic [CW-1:0] timeout_count;
    logic [2:0]    sched_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] m_next, m_lead, m_interval, last_fire_tsf;
    int          m_miss;

    beacon_scheduler #(.CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .beacon_interval  (beacon_interval),
        .max_lead         (max_lead),
        .timeout_us       (timeout_us),
        .tsf_runtime_val  (tsf_runtime_val),
        .tsf_load         (tsf_load),
        .prosessing_delay (prosessing_delay),
        .sent_beacon      (sent_beacon),
        .start_beaconing  (start_beaconing),
        .beacon_busy      (beacon_busy),
        .next_tbtt        (next_tbtt),
        .miss_count       (miss_count),
        .timeout_count    (timeout_count),
        .sched_state      (sched_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; sent_beacon = 1'b0; tsf_load = 1'b0; timeout_us = '0;
        tsf_runtime_val = '0;
        tick(); tick();
        rst = 1'b0;
        m_miss = 0;
    endtask

    task automatic cfg(input logic [63:0] interval, input logic [63:0] delay, input logic [63:0] ml);
        beacon_interval  = interval[31:0];
        prosessing_delay = delay;
        max_lead         = ml[15:0];
        m_interval       = interval;
        m_lead           = (delay < ml) ? delay : ml;
    endtask

    task automatic arm_at(input logic [63:0] start);
        tsf_runtime_val = start;
        enable = 1'b1;
        tick();
        m_next = start + m_interval;
        n_checks++; if (sched_state !== 3'd2) begin n_errors++; $display("FAIL arm_state got=%0d exp=2", sched_state); end
        n_checks++; if (next_tbtt !== m_next) begin n_errors++; $display("FAIL arm_next got=%0d exp=%0d", next_tbtt, m_next); end
    endtask

    // Runs TSF forward one microsecond per cycle until the pulse; leaves the FSM in WAIT_SENT.
    task automatic wait_fire(input string tag);
        logic [63:0] tgt, t;
        bit seen;
        tgt = m_next - m_lead - 64'd5;
        if (tgt > tsf_runtime_val) tsf_runtime_val = tgt;
        seen = 1'b0;
        t = '0;
        for (int i = 0; i < 60 && !seen; i++) begin
            t = tsf_runtime_val;
            tick();
            if (start_beaconing === 1'b1) seen = 1'b1;
            else tsf_runtime_val = tsf_runtime_val + 64'd1;
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL %s_fire no pulse, exp at tsf=%0d", tag, m_next - m_lead + 64'd1); end
        else if (t !== m_next - m_lead + 64'd1) begin n_errors++; $display("FAIL %s_fire_tsf got=%0d exp=%0d", tag, t, m_next - m_lead + 64'd1); end
        n_checks++; if (beacon_busy !== 1'b1 || sched_state !== 3'd3) begin n_errors++; $display("FAIL %s_fire_busy busy=%0b state=%0d exp busy=1 state=3", tag, beacon_busy, sched_state); end
        last_fire_tsf = t;
        tick();
        n_checks++; if (start_beaconing !== 1'b0 || sched_state !== 3'd4) begin n_errors++; $display("FAIL %s_one_cycle start=%0b state=%0d exp start=0 state=4", tag, start_beaconing, sched_state); end
    endtask

    task automatic send(input string tag, input logic [63:0] ts);
        tsf_runtime_val = ts;
        sent_beacon = 1'b1;
        tick();
        sent_beacon = 1'b0;
        m_next = m_next + m_interval;
        n_checks++; if (sched_state !== 3'd1 || beacon_busy !== 1'b0) begin n_errors++; $display("FAIL %s_sent state=%0d busy=%0b exp state=1 busy=0", tag, sched_state, beacon_busy); end
        n_checks++; if (next_tbtt !== m_next) begin n_errors++; $display("FAIL %s_sent_next got=%0d exp=%0d", tag, next_tbtt, m_next); end
        while (ts + m_lead > m_next) begin
            m_next = m_next + m_interval;
            m_miss = (m_miss < (1 << CW) - 1) ? m_miss + 1 : m_miss;
        end
        for (int i = 0; i < 80 && sched_state === 3'd1; i++) tick();
        n_checks++; if (sched_state !== 3'd2) begin n_errors++; $display("FAIL %s_rearm state got=%0d exp=2", tag, sched_state); end
        n_checks++; if (next_tbtt !== m_next) begin n_errors++; $display("FAIL %s_rearm_next got=%0d exp=%0d", tag, next_tbtt, m_next); end
        n_checks++; if (miss_count !== CW'(m_miss)) begin n_errors++; $display("FAIL %s_miss got=%0d exp=%0d", tag, miss_count, m_miss); end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (start_beaconing !== 1'b0) begin n_errors++; $display("FAIL reset_start got=%0b exp=0", start_beaconing); end
        n_checks++; if (beacon_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%0b exp=0", beacon_busy); end
        n_checks++; if (next_tbtt !== 64'd0) begin n_errors++; $display("FAIL reset_next got=%0d exp=0", next_tbtt); end
        n_checks++; if (miss_count !== '0 || timeout_count !== '0) begin n_errors++; $display("FAIL reset_counts miss=%0d tmo=%0d exp 0", miss_count, timeout_count); end
        n_checks++; if (sched_state !== 3'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", sched_state); end
    endtask

    task automatic test_basic();
        do_reset();
        cfg(64'd102400, 64'd0, 64'd100);
        arm_at(64'd1000);
        n_checks++; if (next_tbtt !== 64'd103400) begin n_errors++; $display("FAIL basic_next got=%0d exp=103400", next_tbtt); end
        wait_fire("basic");
        send("basic", 64'd103500);
        n_checks++; if (next_tbtt !== 64'd205800) begin n_errors++; $display("FAIL basic_after_sent got=%0d exp=205800", next_tbtt); end
    endtask

    task automatic test_lead();
        do_reset();
        cfg(64'd102400, 64'd50, 64'd30);
        arm_at(64'd1000);
        wait_fire("lead_clamped");
        n_checks++; if (last_fire_tsf !== 64'd103371) begin n_errors++; $display("FAIL lead30_tsf got=%0d exp=103371", last_fire_tsf); end
        do_reset();
        cfg(64'd102400, 64'd50, 64'd100);
        arm_at(64'd1000);
        wait_fire("lead_delay");
        n_checks++; if (last_fire_tsf !== 64'd103351) begin n_errors++; $display("FAIL lead50_tsf got=%0d exp=103351", last_fire_tsf); end
    endtask

    task automatic test_miss();
        do_reset();
        cfg(64'd102400, 64'd0, 64'd100);
        arm_at(64'd1000);
        wait_fire("miss");
        send("miss", 64'd310000);
        n_checks++; if (miss_count !== CW'(2) || next_tbtt !== 64'd410600) begin n_errors++; $display("FAIL miss_spec miss=%0d next=%0d exp miss=2 next=410600", miss_count, next_tbtt); end
    endtask

    task automatic test_random();
        logic [63:0] start, ts;
        int k;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            cfg(64'($urandom_range(200000, 1000)), 64'($urandom_range(400, 0)), 64'($urandom_range(400, 0)));
            start = 64'($urandom_range(32'h3fff_ffff, 0));
            arm_at(start);
            wait_fire("rnd");
            k = $urandom_range(3, 0);
            ts = m_next + 64'(k) * m_interval - m_lead + 64'($urandom_range(int'(m_interval) - 10, 1));
            send("rnd", ts);
            wait_fire("rnd_next");
        end
    endtask

    task automatic test_tsf_load();
        bit bad;
        do_reset();
        cfg(64'd102400, 64'd0, 64'd100);
        arm_at(64'd1000);
        tick();
        tsf_runtime_val = 64'd5000; tsf_load = 1'b1;
        tick();
        tsf_load = 1'b0;
        m_next = 64'd107400;
        n_checks++; if (next_tbtt !== 64'd107400 || sched_state !== 3'd2) begin n_errors++; $display("FAIL load_wait next=%0d state=%0d exp next=107400 state=2", next_tbtt, sched_state); end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tsf_runtime_val = tsf_runtime_val + 64'd1;
            tick();
            if (start_beaconing !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_errors++; $display("FAIL load_spurious start seen=1 exp=0"); end
        wait_fire("load");
        tsf_runtime_val = 64'd2000; tsf_load = 1'b1;
        tick();
        tsf_load = 1'b0;
        m_next = 64'd104400;
        n_checks++; if (sched_state !== 3'd2 || beacon_busy !== 1'b1 || next_tbtt !== 64'd104400) begin n_errors++; $display("FAIL load_busy state=%0d busy=%0b next=%0d exp 2/1/104400", sched_state, beacon_busy, next_tbtt); end
        tsf_runtime_val = 64'd104500;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (start_beaconing !== 1'b0 || sched_state !== 3'd2) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_errors++; $display("FAIL load_hold fired while busy, exp hold in WAIT"); end
        sent_beacon = 1'b1;
        tick();
        sent_beacon = 1'b0;
        n_checks++; if (beacon_busy !== 1'b0 || sched_state !== 3'd2 || next_tbtt !== 64'd104400) begin n_errors++; $display("FAIL load_sent busy=%0b state=%0d next=%0d exp 0/2/104400", beacon_busy, sched_state, next_tbtt); end
        bad = 1'b1;
        for (int i = 0; i < 4 && bad; i++) begin
            tick();
            if (start_beaconing === 1'b1) bad = 1'b0;
        end
        n_checks++; if (bad) begin n_errors++; $display("FAIL load_refire no pulse after busy cleared, exp pulse"); end
    endtask

    task automatic test_disable();
        do_reset();
        cfg(64'd102400, 64'd0, 64'd100);
        arm_at(64'd1000);
        wait_fire("dis");
        send("dis", 64'd205850);
        wait_fire("dis2");
        enable = 1'b0;
        tick();
        n_checks++; if (sched_state !== 3'd0 || beacon_busy !== 1'b0 || miss_count !== CW'(1)) begin n_errors++; $display("FAIL dis_idle state=%0d busy=%0b miss=%0d exp 0/0/1", sched_state, beacon_busy, miss_count); end
        sent_beacon = 1'b1;
        tick();
        sent_beacon = 1'b0;
        n_checks++; if (sched_state !== 3'd0 || beacon_busy !== 1'b0 || miss_count !== CW'(1)) begin n_errors++; $display("FAIL dis_sent state=%0d busy=%0b miss=%0d exp 0/0/1", sched_state, beacon_busy, miss_count); end
        beacon_interval = '0; enable = 1'b1;
        tick(); tick();
        n_checks++; if (sched_state !== 3'd0) begin n_errors++; $display("FAIL dis_zero_interval state=%0d exp=0", sched_state); end
        rst = 1'b1;
        tick();
        rst = 1'b0; enable = 1'b0;
        n_checks++; if (miss_count !== '0 || next_tbtt !== 64'd0 || sched_state !== 3'd0 || beacon_busy !== 1'b0) begin n_errors++; $display("FAIL dis_rst miss=%0d next=%0d state=%0d busy=%0b exp all 0", miss_count, next_tbtt, sched_state, beacon_busy); end
    endtask

    task automatic test_saturate();
        do_reset();
        cfg(64'd1, 64'd0, 64'd0);
        arm_at(64'd100);
        wait_fire("sat");
        send("sat", 64'd140);
        n_checks++; if (miss_count !== {CW{1'b1}}) begin n_errors++; $display("FAIL sat_miss got=%0d exp=%0d", miss_count, (1 << CW) - 1); end
    endtask

`ifdef BEACON_TIMEOUT_EN
    task automatic test_timeout();
        logic [63:0] e;
        do_reset();
        cfg(64'd102400, 64'd0, 64'd100);
        timeout_us = 32'd500;
        arm_at(64'd1000);
        wait_fire("tmo");
        e = last_fire_tsf;
        tsf_runtime_val = e + 64'd499;
        tick();
        n_checks++; if (sched_state !== 3'd4 || timeout_count !== '0) begin n_errors++; $display("FAIL tmo_early state=%0d tmo=%0d exp 4/0", sched_state, timeout_count); end
        tsf_runtime_val = e + 64'd500;
        tick();
        n_checks++; if (sched_state !== 3'd1 || timeout_count !== CW'(1) || beacon_busy !== 1'b0) begin n_errors++; $display("FAIL tmo_hit state=%0d tmo=%0d busy=%0b exp 1/1/0", sched_state, timeout_count, beacon_busy); end
        n_checks++; if (next_tbtt !== 64'd205800) begin n_errors++; $display("FAIL tmo_next got=%0d exp=205800", next_tbtt); end
        do_reset();
        cfg(64'd102400, 64'd0, 64'd100);
        timeout_us = 32'd500;
        arm_at(64'd1000);
        wait_fire("tmo_sent");
        tsf_runtime_val = last_fire_tsf + 64'd500; sent_beacon = 1'b1;
        tick();
        sent_beacon = 1'b0;
        n_checks++; if (sched_state !== 3'd1 || timeout_count !== '0) begin n_errors++; $display("FAIL tmo_vs_sent state=%0d tmo=%0d exp 1/0", sched_state, timeout_count); end
        do_reset();
        cfg(64'd102400, 64'd0, 64'd100);
        arm_at(64'd1000);
        wait_fire("tmo_zero");
        tsf_runtime_val = last_fire_tsf + 64'd100000;
        tick();
        n_checks++; if (sched_state !== 3'd4 || timeout_count !== '0) begin n_errors++; $display("FAIL tmo_zero state=%0d tmo=%0d exp 4/0", sched_state, timeout_count); end
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        cfg(64'd102400, 64'd0, 64'd100);
        timeout_us = 32'd500;
        arm_at(64'd1000);
        wait_fire("notmo");
        tsf_runtime_val = last_fire_tsf + 64'd100000;
        tick(); tick();
        n_checks++; if (sched_state !== 3'd4 || timeout_count !== '0 || beacon_busy !== 1'b1) begin n_errors++; $display("FAIL notmo state=%0d tmo=%0d busy=%0b exp 4/0/1", sched_state, timeout_count, beacon_busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_lead();
        test_miss();
        test_random();
        test_tsf_load();
        test_disable();
        test_saturate();
`ifdef BEACON_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
